// File: rtl/gpio_bank.sv
// Multi-pin GPIO bank: output/OE registers, synchronised inputs, edge-detect interrupts.
// Optional debounce filter on the input path enabled by GPIO_BANK_DEBOUNCE_EN.
module gpio_bank #(
   parameter int WIDTH           = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [WIDTH-1:0]     gpio_in_i,
   output logic [WIDTH-1:0]     gpio_out_o,
   output logic [WIDTH-1:0]     gpio_oe_o,
   input  logic                 out_wr_i,
   input  logic [WIDTH-1:0]     out_wdata_i,
   input  logic [WIDTH-1:0]     out_set_i,
   input  logic [WIDTH-1:0]     out_clr_i,
   input  logic                 oe_wr_i,
   input  logic [WIDTH-1:0]     oe_wdata_i,
   input  logic [2*WIDTH-1:0]   irq_mode_i,
   input  logic [WIDTH-1:0]     irq_clr_i,
   output logic [WIDTH-1:0]     gpio_sync_o,
   output logic [WIDTH-1:0]     irq_pending_o,
   output logic                 irq_o
);

   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("gpio_bank: WIDTH out of range");
   end
   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("gpio_bank: SYNC_STAGES out of range");
   end
   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_deb
      $error("gpio_bank: DEBOUNCE_CYCLES out of range");
   end

   localparam int VW = $clog2(SYNC_STAGES + 2);
   localparam logic [VW-1:0] VLD_MAX = VW'(SYNC_STAGES + 1);

   logic [WIDTH-1:0] out_q, out_next, oe_q;
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] sync_raw, filt, prev_q, pend_q;
   logic [WIDTH-1:0] rise, fall, det;
   logic [VW-1:0]    vld_cnt_q;
   logic             edge_en, irq_q;

   // Clear is applied last so it beats both a write and a set on the same bit.
   always_comb begin
      out_next = out_wr_i ? out_wdata_i : out_q;
      out_next = (out_next | out_set_i) & ~out_clr_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_q <= '0;
         oe_q  <= '0;
      end else begin
         out_q <= out_next;
         if (oe_wr_i) oe_q <= oe_wdata_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in_i};
   end

   assign sync_raw = sync_q[SYNC_STAGES-1];

`ifdef GPIO_BANK_DEBOUNCE_EN
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0][DW-1:0] db_cnt_q;
   logic [WIDTH-1:0]         filt_q;

   // A pin's filtered value follows the synchroniser only after it has
   // disagreed for DEBOUNCE_CYCLES consecutive cycles.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         db_cnt_q <= '0;
         filt_q   <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (sync_raw[i] == filt_q[i]) begin
               db_cnt_q[i] <= '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
               filt_q[i]   <= sync_raw[i];
               db_cnt_q[i] <= '0;
            end else begin
               db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign filt = filt_q;
`else
   assign filt = sync_raw;
`endif

   // Edges stay masked until the synchroniser and prev register hold real data.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                   vld_cnt_q <= '0;
      else if (vld_cnt_q != VLD_MAX) vld_cnt_q <= vld_cnt_q + 1'b1;
   end

   assign edge_en = (vld_cnt_q == VLD_MAX);
   assign rise    = filt & ~prev_q;
   assign fall    = ~filt & prev_q;

   always_comb begin
      det = '0;
      for (int i = 0; i < WIDTH; i++) begin
         det[i] = edge_en & ((irq_mode_i[2*i] & rise[i]) | (irq_mode_i[2*i+1] & fall[i]));
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prev_q <= '0;
         pend_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         prev_q <= filt;
         pend_q <= (pend_q & ~irq_clr_i) | det;
         irq_q  <= |pend_q;
      end
   end

   assign gpio_out_o    = out_q;
   assign gpio_oe_o     = oe_q;
   assign gpio_sync_o   = filt;
   assign irq_pending_o = pend_q;
   assign irq_o         = irq_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank: reset, output precedence table, edge/irq
// sequences, debounce (when GPIO_BANK_DEBOUNCE_EN) and a randomized model comparison.
module tb_gpio_bank;
   localparam int W    = 8;
   localparam int SYNC = 2;
   localparam int DEB  = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [W-1:0]   gpio_in = '0;
   logic [W-1:0]   gpio_out, gpio_oe, gpio_sync, irq_pending;
   logic           out_wr = 1'b0;
   logic [W-1:0]   out_wdata = '0, out_set = '0, out_clr = '0;
   logic           oe_wr = 1'b0;
   logic [W-1:0]   oe_wdata = '0;
   logic [2*W-1:0] irq_mode = '0;
   logic [W-1:0]   irq_clr = '0;
   logic           irq;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   gpio_bank #(.WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
      .clk_i(clk), .rst_i(rst), .gpio_in_i(gpio_in),
      .gpio_out_o(gpio_out), .gpio_oe_o(gpio_oe),
      .out_wr_i(out_wr), .out_wdata_i(out_wdata), .out_set_i(out_set), .out_clr_i(out_clr),
      .oe_wr_i(oe_wr), .oe_wdata_i(oe_wdata),
      .irq_mode_i(irq_mode), .irq_clr_i(irq_clr),
      .gpio_sync_o(gpio_sync), .irq_pending_o(irq_pending), .irq_o(irq)
   );

   typedef struct {
      logic       wr;
      logic [7:0] wd;
      logic [7:0] set;
      logic [7:0] clr;
      logic       oe_wr;
      logic [7:0] oe_wd;
      logic [7:0] exp_out;
      logic [7:0] exp_oe;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   // Inputs change just after a falling edge; outputs are sampled there too.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_ctrl();
      out_wr = 1'b0; out_wdata = '0; out_set = '0; out_clr = '0;
      oe_wr = 1'b0; oe_wdata = '0; irq_clr = '0;
   endtask

   task automatic do_reset(input logic [7:0] v);
      rst = 1'b1;
      gpio_in = v;
      clear_ctrl();
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Reference model state
   logic [7:0] hist[$];
   logic [7:0] m_out, m_oe, m_sync, m_prev, m_pend;
   logic       m_irq;
   int         m_edges;

   task automatic model_init();
      hist = {};
      for (int i = 0; i < SYNC; i++) hist.push_back(8'h00);
      m_out = '0; m_oe = '0; m_sync = '0; m_prev = '0; m_pend = '0;
      m_irq = 1'b0; m_edges = 0;
   endtask

   task automatic model_edge();
      logic [7:0] old_sync, old_prev, old_pend, det;
      logic [1:0] mode;
      logic       rose, fell, valid;
      old_sync = m_sync; old_prev = m_prev; old_pend = m_pend;
      valid = (m_edges >= SYNC + 1);
      det = '0;
      for (int p = 0; p < W; p++) begin
         mode = irq_mode[2*p +: 2];
         rose = old_sync[p] && !old_prev[p];
         fell = !old_sync[p] && old_prev[p];
         if (valid && ((mode == 2'd1 && rose) || (mode == 2'd2 && fell) || (mode == 2'd3 && (rose || fell))))
            det[p] = 1'b1;
      end
      hist.push_front(gpio_in);
      void'(hist.pop_back());
      m_sync = hist[SYNC-1];
      m_prev = old_sync;
      m_pend = (old_pend & ~irq_clr) | det;
      m_irq  = (old_pend != 0);
      if (m_edges < 100) m_edges++;
      if (out_wr) m_out = out_wdata;
      for (int p = 0; p < W; p++) begin
         if (out_set[p]) m_out[p] = 1'b1;
         if (out_clr[p]) m_out[p] = 1'b0;
      end
      if (oe_wr) m_oe = oe_wdata;
   endtask

   initial begin
      int idx;
      vecs[0] = '{1'b1, 8'hA5, 8'h00, 8'h00, 1'b0, 8'h00, 8'hA5, 8'h00};
      vecs[1] = '{1'b0, 8'h00, 8'h0F, 8'h01, 1'b0, 8'h00, 8'hAE, 8'h00};
      vecs[2] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 8'hF0, 8'hAE, 8'hF0};
      vecs[3] = '{1'b1, 8'h3C, 8'h01, 8'h04, 1'b0, 8'h00, 8'h39, 8'hF0};
      vecs[4] = '{1'b0, 8'h00, 8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00, 8'hF0};
      vecs[5] = '{1'b0, 8'h00, 8'h81, 8'h00, 1'b0, 8'h00, 8'h81, 8'hF0};
      vecs[6] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h81, 8'hF0};
      vecs[7] = '{1'b1, 8'h00, 8'h10, 8'h00, 1'b1, 8'h0F, 8'h10, 8'h0F};

      @(negedge clk);
      // Reset state with inputs held high through reset
`ifdef GPIO_BANK_DEBOUNCE_EN
      irq_mode = 16'h0000;
`else
      irq_mode = 16'h5555;
`endif
      gpio_in = 8'hFF;
      tick();
      chk("rst_out", gpio_out, 8'h00);
      chk("rst_oe", gpio_oe, 8'h00);
      chk("rst_sync", gpio_sync, 8'h00);
      chk("rst_pend", irq_pending, 8'h00);
      chk("rst_irq", irq, 1'b0);
      rst = 1'b0;
      repeat (10) tick();
      chk("post_rst_sync", gpio_sync, 8'hFF);
      chk("post_rst_pend", irq_pending, 8'h00);
      chk("post_rst_irq", irq, 1'b0);
      irq_mode = '0;

      for (int v = 0; v < 8; v++) begin
         out_wr = vecs[v].wr; out_wdata = vecs[v].wd;
         out_set = vecs[v].set; out_clr = vecs[v].clr;
         oe_wr = vecs[v].oe_wr; oe_wdata = vecs[v].oe_wd;
         tick();
         chk($sformatf("vec%0d_out", v), gpio_out, vecs[v].exp_out);
         chk($sformatf("vec%0d_oe", v), gpio_oe, vecs[v].exp_oe);
      end
      clear_ctrl();

`ifndef GPIO_BANK_DEBOUNCE_EN
      // Edge modes: pin0 rise, pin1 fall, pin2 both, pin3 off
      irq_mode = 16'h0039;
      do_reset(8'h00);
      repeat (10) tick();
      chk("mode_idle_pend", irq_pending, 8'h00);
      gpio_in = 8'h0F;
      repeat (3) tick();
      chk("rise_pend", irq_pending, 8'h05);
      chk("rise_irq_lag", irq, 1'b0);
      tick();
      chk("rise_irq", irq, 1'b1);
      gpio_in = 8'h00;
      repeat (4) tick();
      chk("fall_pend", irq_pending, 8'h07);

      // Set beats clear on the same cycle
      gpio_in = 8'h01;
      repeat (2) tick();
      irq_clr = 8'h01;
      tick();
      irq_clr = 8'h00;
      chk("set_wins_clr", irq_pending, 8'h07);
      irq_clr = 8'h01;
      tick();
      irq_clr = 8'h00;
      chk("clr_bit0", irq_pending, 8'h06);
      chk("clr_bit0_irq", irq, 1'b1);
      irq_clr = 8'hFF;
      tick();
      irq_clr = 8'h00;
      chk("clr_all_pend", irq_pending, 8'h00);
      chk("clr_all_irq_lag", irq, 1'b1);
      tick();
      chk("clr_all_irq", irq, 1'b0);

      // Latency on pin 5
      irq_mode = 16'h0400;
      gpio_in = 8'h21;
      tick();
      chk("lat_sync_n1", gpio_sync, 8'h01);
      tick();
      chk("lat_sync_n2", gpio_sync, 8'h21);
      chk("lat_pend_n2", irq_pending, 8'h00);
      tick();
      chk("lat_pend_n3", irq_pending, 8'h20);
      chk("lat_irq_n3", irq, 1'b0);
      tick();
      chk("lat_irq_n4", irq, 1'b1);
      irq_mode = 16'h0000;
      tick();
      chk("mode_chg_keeps", irq_pending, 8'h20);
`else
      // Debounce on pin 6
      irq_mode = 16'h1000;
      do_reset(8'h00);
      repeat (10) tick();
      gpio_in = 8'h40;
      repeat (3) tick();
      gpio_in = 8'h00;
      for (int t = 0; t < 10; t++) begin
         tick();
         chk($sformatf("glitch_sync_t%0d", t), gpio_sync, 8'h00);
      end
      chk("glitch_pend", irq_pending, 8'h00);
      gpio_in = 8'h40;
      for (int t = 1; t <= 6; t++) begin
         tick();
         if (t == 5) chk("deb_sync_t5", gpio_sync, 8'h00);
         if (t == 6) chk("deb_sync_t6", gpio_sync, 8'h40);
      end
      gpio_in = 8'h00;
      tick();
      chk("deb_pend", irq_pending, 8'h40);
`endif

      // Asynchronous reset in the middle of a cycle
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_out", gpio_out, 8'h00);
      chk("midrst_oe", gpio_oe, 8'h00);
      chk("midrst_sync", gpio_sync, 8'h00);
      chk("midrst_pend", irq_pending, 8'h00);
      chk("midrst_irq", irq, 1'b0);
      @(negedge clk);

`ifndef GPIO_BANK_DEBOUNCE_EN
      clear_ctrl();
      irq_mode = 16'($urandom);
      gpio_in = 8'($urandom);
      tick();
      model_init();
      rst = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 2) == 0) begin
            idx = $urandom_range(0, W - 1);
            gpio_in[idx] = ~gpio_in[idx];
         end
         out_wr    = ($urandom_range(0, 3) == 0);
         out_wdata = 8'($urandom);
         out_set   = 8'($urandom & $urandom & $urandom);
         out_clr   = 8'($urandom & $urandom & $urandom);
         oe_wr     = ($urandom_range(0, 5) == 0);
         oe_wdata  = 8'($urandom);
         irq_clr   = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
         if ($urandom_range(0, 31) == 0) irq_mode = 16'($urandom);
         tick();
         model_edge();
         chk($sformatf("rnd%0d_out", c), gpio_out, m_out);
         chk($sformatf("rnd%0d_oe", c), gpio_oe, m_oe);
         chk($sformatf("rnd%0d_sync", c), gpio_sync, m_sync);
         chk($sformatf("rnd%0d_pend", c), irq_pending, m_pend);
         chk($sformatf("rnd%0d_irq", c), irq, m_irq);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
